// File: rtl/wb_regfile.sv
// Dual-issue writeback stage with a 2-write / 4-read register file.
// Read ports bypass same-cycle writes; slot 2 is younger and wins on rd conflicts.
module wb_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] readdata_1,
  input  logic [XLEN-1:0] resultalu_1,
  input  logic [4:0]      rd_1,
  input  logic            memtoreg_1,
  input  logic            regwrite_1,
  input  logic [XLEN-1:0] readdata_2,
  input  logic [XLEN-1:0] resultalu_2,
  input  logic [4:0]      rd_2,
  input  logic            memtoreg_2,
  input  logic            regwrite_2,
  input  logic [4:0]      rs1_a,
  input  logic [4:0]      rs2_a,
  input  logic [4:0]      rs1_b,
  input  logic [4:0]      rs2_b,
  output logic [XLEN-1:0] rdata1_a,
  output logic [XLEN-1:0] rdata2_a,
  output logic [XLEN-1:0] rdata1_b,
  output logic [XLEN-1:0] rdata2_b,
  output logic [XLEN-1:0] wb_data_1,
  output logic [XLEN-1:0] wb_data_2,
  output logic            wb_we_1,
  output logic            wb_we_2,
  output logic [31:0]     retired_writes
);

  logic [XLEN-1:0] regs [NREG];
  logic            conflict;
  logic            commit_1;
  logic [1:0]      incr;
  logic [4:0]      addr  [4];
  logic [XLEN-1:0] rdata [4];

  assign wb_data_1 = memtoreg_1 ? readdata_1 : resultalu_1;
  assign wb_data_2 = memtoreg_2 ? readdata_2 : resultalu_2;
  assign wb_we_1   = regwrite_1 && (rd_1 != '0) && !reset;
  assign wb_we_2   = regwrite_2 && (rd_2 != '0) && !reset;

  // A same-rd dual write is a single architectural write carrying slot 2's value.
  assign conflict = wb_we_1 && wb_we_2 && (rd_1 == rd_2);
  assign commit_1 = wb_we_1 && !conflict;
  assign incr     = {1'b0, commit_1} + {1'b0, wb_we_2};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      retired_writes <= '0;
    end else begin
      if (commit_1 && (32'(rd_1) < NREG)) begin
        regs[rd_1] <= wb_data_1;
      end
      if (wb_we_2 && (32'(rd_2) < NREG)) begin
        regs[rd_2] <= wb_data_2;
      end
      retired_writes <= retired_writes + 32'(incr);
    end
  end

  assign addr[0] = rs1_a;
  assign addr[1] = rs2_a;
  assign addr[2] = rs1_b;
  assign addr[3] = rs2_b;

  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      rdata[p] = '0;
      if (!reset && (addr[p] != '0)) begin
        if (wb_we_2 && (addr[p] == rd_2)) begin
          rdata[p] = wb_data_2;
        end else if (wb_we_1 && (addr[p] == rd_1)) begin
          rdata[p] = wb_data_1;
        end else if (32'(addr[p]) < NREG) begin
          rdata[p] = regs[addr[p]];
        end
      end
    end
  end

  assign rdata1_a = rdata[0];
  assign rdata2_a = rdata[1];
  assign rdata1_b = rdata[2];
  assign rdata2_b = rdata[3];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: architectural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] readdata_1, resultalu_1, readdata_2, resultalu_2;
  logic [4:0]  rd_1, rd_2;
  logic        memtoreg_1, regwrite_1, memtoreg_2, regwrite_2;
  logic [4:0]  rs1_a, rs2_a, rs1_b, rs2_b;
  logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic [31:0] wb_data_1, wb_data_2;
  logic        wb_we_1, wb_we_2;
  logic [31:0] retired_writes;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .readdata_1(readdata_1), .resultalu_1(resultalu_1), .rd_1(rd_1),
    .memtoreg_1(memtoreg_1), .regwrite_1(regwrite_1),
    .readdata_2(readdata_2), .resultalu_2(resultalu_2), .rd_2(rd_2),
    .memtoreg_2(memtoreg_2), .regwrite_2(regwrite_2),
    .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_b(rs1_b), .rs2_b(rs2_b),
    .rdata1_a(rdata1_a), .rdata2_a(rdata2_a), .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
    .wb_data_1(wb_data_1), .wb_data_2(wb_data_2),
    .wb_we_1(wb_we_1), .wb_we_2(wb_we_2),
    .retired_writes(retired_writes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  logic        chk_en  = 1'b0;
  logic [31:0] mreg [32];
  logic [31:0] mcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a write happens when enabled, not in reset, and not aimed at r0.
  function automatic logic m_we1();
    return regwrite_1 && !reset && rd_1 != 5'd0;
  endfunction
  function automatic logic m_we2();
    return regwrite_2 && !reset && rd_2 != 5'd0;
  endfunction
  function automatic logic [31:0] m_wd1();
    return memtoreg_1 ? readdata_1 : resultalu_1;
  endfunction
  function automatic logic [31:0] m_wd2();
    return memtoreg_2 ? readdata_2 : resultalu_2;
  endfunction

  // Read value = register contents after this cycle's writes applied in program order.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    if (reset || a == 5'd0) return 32'h0;
    v = mreg[a];
    if (m_we1() && rd_1 == a) v = m_wd1();
    if (m_we2() && rd_2 == a) v = m_wd2();
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mcount = 32'h0;
      end else begin
        int n;
        n = 0;
        if (m_we1()) begin mreg[rd_1] = m_wd1(); n++; end
        if (m_we2()) begin mreg[rd_2] = m_wd2(); n++; end
        if (m_we1() && m_we2() && rd_1 == rd_2) n--;
        mcount = mcount + 32'(n);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rdata1_a", rdata1_a, m_read(rs1_a));
        check("rdata2_a", rdata2_a, m_read(rs2_a));
        check("rdata1_b", rdata1_b, m_read(rs1_b));
        check("rdata2_b", rdata2_b, m_read(rs2_b));
        check("wb_data_1", wb_data_1, m_wd1());
        check("wb_data_2", wb_data_2, m_wd2());
        check("wb_we_1", {31'h0, wb_we_1}, {31'h0, m_we1()});
        check("wb_we_2", {31'h0, wb_we_2}, {31'h0, m_we2()});
        check("retired_writes", retired_writes, mcount);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic idle();
    readdata_1 = 32'h0; resultalu_1 = 32'h0; rd_1 = 5'd0; memtoreg_1 = 1'b0; regwrite_1 = 1'b0;
    readdata_2 = 32'h0; resultalu_2 = 32'h0; rd_2 = 5'd0; memtoreg_2 = 1'b0; regwrite_2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    rs1_a = 5'd0; rs2_a = 5'd0; rs1_b = 5'd0; rs2_b = 5'd0;
    tick();
    chk_en = 1'b1;
    tick();

    // Basic write with same-cycle bypass
    reset = 1'b0;
    rd_1 = 5'd5; resultalu_1 = 32'h1234; regwrite_1 = 1'b1; rs1_a = 5'd5;
    @(negedge clk);
    check("basic_bypass", rdata1_a, 32'h0000_1234);
    check("basic_we1", {31'h0, wb_we_1}, 32'h1);
    tick();
    idle();
    @(negedge clk);
    check("basic_array", rdata1_a, 32'h0000_1234);
    check("basic_count", retired_writes, 32'h1);

    // Same-rd conflict
    tick();
    rd_1 = 5'd7; resultalu_1 = 32'hAAAA; regwrite_1 = 1'b1;
    rd_2 = 5'd7; resultalu_2 = 32'hBBBB; regwrite_2 = 1'b1;
    rs1_b = 5'd7;
    @(negedge clk);
    check("conflict_bypass", rdata1_b, 32'h0000_BBBB);
    tick();
    idle();
    @(negedge clk);
    check("conflict_array", rdata1_b, 32'h0000_BBBB);
    check("conflict_count", retired_writes, 32'h2);

    // Dual write with load select on slot 1
    tick();
    rd_1 = 5'd3; memtoreg_1 = 1'b1; readdata_1 = 32'hDEAD_BEEF; resultalu_1 = 32'h5555; regwrite_1 = 1'b1;
    rd_2 = 5'd4; memtoreg_2 = 1'b0; readdata_2 = 32'h9999; resultalu_2 = 32'h10; regwrite_2 = 1'b1;
    rs2_a = 5'd3; rs2_b = 5'd4;
    tick();
    idle();
    @(negedge clk);
    check("dual_r3", rdata2_a, 32'hDEAD_BEEF);
    check("dual_r4", rdata2_b, 32'h0000_0010);
    check("dual_count", retired_writes, 32'h4);

    // Register 0 writes are discarded
    tick();
    rd_2 = 5'd0; resultalu_2 = 32'hFFFF_FFFF; regwrite_2 = 1'b1;
    rs1_a = 5'd0; rs2_a = 5'd0; rs1_b = 5'd0; rs2_b = 5'd0;
    @(negedge clk);
    check("r0_bypass", rdata1_a, 32'h0);
    check("r0_we2", {31'h0, wb_we_2}, 32'h0);
    check("r0_wbdata", wb_data_2, 32'hFFFF_FFFF);
    tick();
    idle();
    @(negedge clk);
    check("r0_array", rdata2_b, 32'h0);
    check("r0_count", retired_writes, 32'h4);

    // Fill r1..r31, then reset mid-run with a write to r9 pending
    for (int i = 1; i < 32; i += 2) begin
      tick();
      rd_1 = 5'(i); resultalu_1 = 32'hA500_0000 | 32'(i); regwrite_1 = 1'b1;
      if (i < 31) begin
        rd_2 = 5'(i + 1); memtoreg_2 = 1'b1; readdata_2 = 32'h5A00_0000 | 32'(i + 1); regwrite_2 = 1'b1;
      end else begin
        rd_2 = 5'd0; regwrite_2 = 1'b0;
      end
      rs1_a = 5'($urandom_range(0, 31)); rs2_a = 5'($urandom_range(0, 31));
      rs1_b = 5'($urandom_range(0, 31)); rs2_b = 5'(i);
    end
    tick();
    idle();
    rs1_a = 5'd9; rs2_a = 5'd1; rs1_b = 5'd31; rs2_b = 5'd5;
    @(negedge clk);
    check("fill_r9", rdata1_a, 32'hA500_0009);
    check("fill_r31", rdata1_b, 32'hA500_001F);
    check("fill_count", retired_writes, 32'd35);
    tick();
    reset = 1'b1;
    rd_1 = 5'd9; resultalu_1 = 32'h999; regwrite_1 = 1'b1;
    @(negedge clk);
    check("rst_rdata1_a", rdata1_a, 32'h0);
    check("rst_rdata2_a", rdata2_a, 32'h0);
    check("rst_rdata1_b", rdata1_b, 32'h0);
    check("rst_rdata2_b", rdata2_b, 32'h0);
    check("rst_we1", {31'h0, wb_we_1}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_a = 5'(i); rs2_a = 5'(31 - i); rs1_b = 5'(i); rs2_b = 5'd9;
      @(negedge clk);
      check("post_rst_read", rdata1_a, 32'h0);
      check("post_rst_count", retired_writes, 32'h0);
      tick();
    end

    // Counter wrap
    rd_1 = 5'd10; resultalu_1 = 32'h11; regwrite_1 = 1'b1;
    rd_2 = 5'd11; resultalu_2 = 32'h22; regwrite_2 = 1'b1;
    force dut.retired_writes = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    @(negedge clk);
    #4;
    release dut.retired_writes;
    tick();
    idle();
    @(negedge clk);
    check("wrap_count", retired_writes, 32'h0000_0001);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
